// File: rtl/if_id_buf.sv
// IF/ID buffer: in-order FIFO of {pc, ins}; push visible at the head 1 cycle later, flush/reset empty it next edge.
// Backpressure: o_pre_ready = not full, independent of decode; a pop while full frees the slot only for the next cycle.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module if_id_buf #(
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pre_valid,
  output logic                   o_pre_ready,
  input  logic [`CPU_WIDTH-1:0]  i_pc,
  input  logic [`INS_WIDTH-1:0]  i_ins,
  input  logic                   i_flush,
  output logic                   o_post_valid,
  input  logic                   i_post_ready,
  output logic [`CPU_WIDTH-1:0]  o_pc,
  output logic [`INS_WIDTH-1:0]  o_ins,
  output logic [$clog2(DEPTH):0] o_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = `CPU_WIDTH;
  localparam int IW = `INS_WIDTH;
  localparam logic [IW-1:0] NOP = IW'(32'h0000_0013);

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] ins;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          kill;
  logic          push;
  logic          pop;

  // Reset behaves exactly like a flush, including masking the head this cycle.
  always_comb begin
    empty        = (cnt == '0);
    kill         = i_flush | i_rst;
    o_pre_ready  = (cnt < CW'(DEPTH));
    o_post_valid = ~empty & ~kill;
    push         = i_pre_valid & o_pre_ready & ~i_flush;
    pop          = o_post_valid & i_post_ready;
    head         = mem[rd_ptr];
    o_cnt        = cnt;
    o_pc         = '0;
    o_ins        = NOP;
    if (!empty) begin
      o_pc  = head.pc;
      o_ins = head.ins;
    end
  end

  always_ff @(posedge i_clk) begin
    if (kill) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        cnt <= cnt + CW'(1);
      else if (pop && !push)
        cnt <= cnt - CW'(1);
    end
  end

  // Storage is left unreset; only the occupancy decides what is visible.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_pc, i_ins};
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: queue-based reference model checked every cycle, plus directed literal scenarios and random traffic.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module tb_if_id_buf;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        pre_valid;
  logic        pre_ready;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        flush;
  logic        post_valid;
  logic        post_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic [$clog2(DEPTH):0] cnt;

  if_id_buf #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_pre_valid(pre_valid), .o_pre_ready(pre_ready),
    .i_pc(pc), .i_ins(ins), .i_flush(flush),
    .o_post_valid(post_valid), .i_post_ready(post_ready),
    .o_pc(out_pc), .o_ins(out_ins), .o_cnt(cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: what leaves the buffer is exactly the queue front.
  always @(posedge clk) begin
    bit mpush, mpop;
    if (rst || flush) begin
      q.delete();
    end else begin
      mpush = pre_valid && (q.size() < DEPTH);
      mpop  = (q.size() != 0) && post_ready;
      if (mpop)  void'(q.pop_front());
      if (mpush) q.push_back('{pc, ins});
    end
  end

  always @(negedge clk) begin
    if (en) begin
      #2;
      chk("m_cnt", 64'(cnt), 64'(q.size()));
      chk("m_pre_ready", 64'(pre_ready), 64'(q.size() < DEPTH));
      chk("m_post_valid", 64'(post_valid), 64'(q.size() != 0 && !flush && !rst));
      chk("m_pc", 64'(out_pc), (q.size() != 0) ? 64'(q[0].pc) : 64'h0);
      chk("m_ins", 64'(out_ins), (q.size() != 0) ? 64'(q[0].ins) : 64'h13);
    end
  end

  task automatic drive(input bit v, input logic [31:0] p, input logic [31:0] i,
                       input bit pr, input bit fl, input bit r);
    @(negedge clk);
    pre_valid = v; pc = p; ins = i; post_ready = pr; flush = fl; rst = r;
    #3;
  endtask

  task automatic idle();
    drive(0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; pre_valid = 0; pc = 0; ins = 0; flush = 0; post_ready = 0;
    @(posedge clk);
    en = 1;

    // Reset state while reset is still held.
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_post_valid", 64'(post_valid), 64'd0);
    chk("rst_pre_ready", 64'(pre_ready), 64'd1);
    chk("rst_pc", 64'(out_pc), 64'h0);
    chk("rst_ins", 64'(out_ins), 64'h13);

    // Fill.
    drive(1, 32'h8000_0000, 32'h0000_0297, 0, 0, 0);
    drive(1, 32'h8000_0004, 32'h0000_0513, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("fill_cnt", 64'(cnt), 64'd2);
    chk("fill_pre_ready", 64'(pre_ready), 64'd0);
    chk("fill_pc", 64'(out_pc), 64'h8000_0000);
    // Drain order.
    drive(0, 0, 0, 1, 0, 0);
    chk("drain_pc2", 64'(out_pc), 64'h8000_0004);
    chk("drain_cnt", 64'(cnt), 64'd1);
    idle();
    chk("drain_valid", 64'(post_valid), 64'd0);
    chk("drain_ins", 64'(out_ins), 64'h13);

    // Full with pop: no push that cycle, slot freed for the next one.
    drive(1, 32'h100, 32'hA, 0, 0, 0);
    drive(1, 32'h104, 32'hB, 0, 0, 0);
    drive(1, 32'h108, 32'hC, 1, 0, 0);
    chk("fullpop_ready", 64'(pre_ready), 64'd0);
    chk("fullpop_cnt", 64'(cnt), 64'd2);
    drive(1, 32'h108, 32'hC, 0, 0, 0);
    chk("fullpop_cnt_next", 64'(cnt), 64'd1);
    chk("fullpop_ready_next", 64'(pre_ready), 64'd1);
    chk("fullpop_head", 64'(out_pc), 64'h104);
    drive(0, 0, 0, 1, 0, 0);
    chk("fullpop_accepted", 64'(cnt), 64'd2);
    drive(0, 0, 0, 1, 0, 0);
    chk("fullpop_c_pc", 64'(out_pc), 64'h108);
    chk("fullpop_c_ins", 64'(out_ins), 64'hC);
    idle();

    // Flush priority over simultaneous push and pop.
    drive(1, 32'h200, 32'hD, 0, 0, 0);
    drive(1, 32'h204, 32'hE, 1, 1, 0);
    chk("flush_valid", 64'(post_valid), 64'd0);
    chk("flush_cnt_now", 64'(cnt), 64'd1);
    idle();
    chk("flush_cnt", 64'(cnt), 64'd0);
    chk("flush_pc", 64'(out_pc), 64'h0);

    // Reset mid-stream.
    drive(1, 32'h300, 32'hF, 0, 0, 0);
    drive(1, 32'h304, 32'h10, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("midrst_valid_now", 64'(post_valid), 64'd0);
    idle();
    chk("midrst_cnt", 64'(cnt), 64'd0);
    chk("midrst_valid", 64'(post_valid), 64'd0);
    chk("midrst_ready", 64'(pre_ready), 64'd1);

    // Streaming: 8 pairs, one in one out; pointers wrap several times.
    for (int k = 0; k < 8; k++) begin
      drive(1, 32'h1000 + 32'(4 * k), 32'h5000 + 32'(k), k != 0, 0, 0);
      if (k != 0) begin
        chk("stream_cnt", 64'(cnt), 64'd1);
        chk("stream_pc", 64'(out_pc), 64'h1000 + 64'(4 * (k - 1)));
      end
    end
    drive(0, 0, 0, 1, 0, 0);
    chk("stream_last_pc", 64'(out_pc), 64'h101C);
    idle();
    chk("stream_empty", 64'(cnt), 64'd0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) == 0);
    end
    idle();
    @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, entry count; power of two, >= 2.
REQ-002 SHALL have port i_clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  one clock; reset is synchronous and active-high.
REQ-004 SHALL have port i_pre_valid  input  1  fetch stage offers a pc/instruction pair.
REQ-005 SHALL have port o_pre_ready  output  1  buffer accepts the offered pair.
REQ-006 SHALL have port i_pc  input  `CPU_WIDTH  pc of offered instruction.
REQ-007 SHALL have port i_ins  input  `INS_WIDTH  offered instruction word.
REQ-008 SHALL have port i_flush  input  1  redirect from execute; discard all entries.
REQ-009 SHALL have port o_post_valid  output  1  head entry is presented to decode.
REQ-010 SHALL have port i_post_ready  input  1  decode consumes head entry.
REQ-011 SHALL have port o_pc  output  `CPU_WIDTH  pc of head entry.
REQ-012 SHALL have port o_ins  output  `INS_WIDTH  instruction of head entry.
REQ-013 SHALL have port o_cnt  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL operate as an in-order FIFO of {pc, ins} pairs with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 SHALL define push = i_pre_valid & o_pre_ready & ~i_flush; pop = o_post_valid & i_post_ready.
REQ-016 SHALL drive o_pre_ready = (o_cnt < DEPTH), independent of i_post_ready; no same-cycle bypass when full.
REQ-017 SHALL drive o_post_valid = (o_cnt != 0) & ~i_flush.
REQ-018 SHALL drive o_pc/o_ins combinationally from the entry at the read pointer when o_cnt != 0.
REQ-019 SHALL drive o_pc = 0 and o_ins = 32'h00000013 (NOP) when o_cnt == 0.
REQ-020 SHALL make a pushed pair visible at the outputs one cycle after the push edge; latency 1, no combinational path from i_pc/i_ins to outputs.
REQ-021 SHALL on push only: write the pair at the write pointer, advance the write pointer, increment o_cnt.
REQ-022 SHALL on pop only: advance the read pointer, decrement o_cnt.
REQ-023 SHALL on push and pop in the same cycle: perform both, leaving o_cnt unchanged.
REQ-024 SHALL never push when full; a pop while full frees the slot for the following cycle only.
REQ-025 SHALL on i_flush: next cycle o_cnt = 0 and both pointers = 0; push and pop in that cycle have no effect; flush takes priority over every other event.
REQ-026 SHALL keep storage contents unchanged when neither push nor flush occurs; the offered pair is not required to be held stable by the producer after acceptance.

Reset
REQ-027 SHALL while i_rst is high at a rising edge set o_cnt = 0 and both pointers = 0; storage need not be reset.
REQ-028 SHALL with i_rst high show o_post_valid = 0 and o_pre_ready = 1 from the first edge onward; o_pc = 0 and o_ins = 32'h00000013.
REQ-029 SHALL treat i_rst asserted mid-operation exactly as a flush; entries in flight are lost.

Verification
REQ-030 SHALL test fill: with DEPTH=2 and i_post_ready=0, push pc 0x80000000 ins 0x00000297, then pc 0x80000004 ins 0x00000513 -> o_cnt=2, o_pre_ready=0, o_pc=0x80000000.
REQ-031 SHALL test drain order: from the full state raise i_post_ready for 2 cycles -> o_pc 0x80000000 then 0x80000004, then o_post_valid=0, o_ins=0x00000013.
REQ-032 SHALL test streaming: continuous valid/ready for 8 pairs with pc stepping by 4 -> each pc appears once and in order, o_cnt stays 1 after the first push, pointers wrap without loss.
REQ-033 SHALL test flush priority: o_cnt=1 with simultaneous push, pop and i_flush -> o_post_valid=0 that cycle, o_cnt=0 next cycle, pushed pair absent.
REQ-034 SHALL test full with pop: o_cnt=2, i_pre_valid=1, i_post_ready=1 -> no push that cycle (o_pre_ready=0), o_cnt=1 next cycle, push accepted the cycle after.
REQ-035 SHALL test reset mid-stream: i_rst high for 1 cycle with o_cnt=2 -> o_cnt=0, o_post_valid=0, o_pre_ready=1 next cycle.
